// File: rtl/sa_pkg.sv
// Shared types and arithmetic helpers for the saturating add/accumulate array.
package sa_pkg;

    // Working width for the helpers; it must cover OUT_W+A_W+B_W+2 of any instance.
    localparam int MAX_W = 128;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_ACC = 1'b1
    } mode_e;

    typedef logic signed [MAX_W-1:0] wide_t;

    typedef struct packed {
        logic  sat;
        wide_t val;
    } clamp_t;

    // Re-scale x from x_frac to out_frac fractional bits. Left shifts keep every
    // bit (the clamp catches overflow); right shifts optionally round half-up.
    function automatic wide_t align_fn(input wide_t x, input int x_frac,
                                       input int out_frac, input bit rnd);
        int    k;
        wide_t r;
        k = out_frac - x_frac;
        r = '0;
        if (k >= 0) begin
            if (k < MAX_W) r = x <<< k;
        end else if (-k < MAX_W) begin
            if (rnd) r = (x + (wide_t'(1) <<< (-k - 1))) >>> (-k);
            else     r = x >>> (-k);
        end
        return r;
    endfunction

    // Clamp x into the out_w-bit signed or unsigned range and flag when it moved.
    function automatic clamp_t clamp_fn(input wide_t x, input int out_w, input bit sgn);
        wide_t  hi;
        wide_t  lo;
        clamp_t c;
        if (sgn) begin
            hi = (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
            lo = -(wide_t'(1) <<< (out_w - 1));
        end else begin
            hi = (wide_t'(1) <<< out_w) - wide_t'(1);
            lo = '0;
        end
        c.sat = 1'b1;
        if (x > hi)      c.val = hi;
        else if (x < lo) c.val = lo;
        else begin
            c.val = x;
            c.sat = 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/sat_accum_array_lane.sv
// One lane: extend, align, add, clamp, accumulator and the stage-1 result register.
module sat_accum_lane
    import sa_pkg::*;
#(
    parameter int A_W      = 16,
    parameter int A_FRAC   = 0,
    parameter int B_W      = 16,
    parameter int B_FRAC   = 0,
    parameter int OUT_W    = 16,
    parameter int OUT_FRAC = 0,
    parameter int SIGNED   = 0,
    parameter int ROUND    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_accept,
    input  logic             i_mode,
    input  logic             i_first,
    input  logic [A_W-1:0]   i_a,
    input  logic [B_W-1:0]   i_b,
    output logic [OUT_W-1:0] o_res,
    output logic             o_sat
);
    localparam logic SGN = (SIGNED != 0);
    localparam bit   RND = (ROUND != 0);

    logic [OUT_W-1:0] r_acc;
    logic [OUT_W-1:0] r_res;
    logic             r_sat;
    wide_t            w_a;
    wide_t            w_b;
    wide_t            w_acc;
    wide_t            w_sum;
    clamp_t           w_cl;
    logic             w_unused_hi;

    assign w_a   = {{(MAX_W-A_W){SGN & i_a[A_W-1]}}, i_a};
    assign w_b   = {{(MAX_W-B_W){SGN & i_b[B_W-1]}}, i_b};
    assign w_acc = {{(MAX_W-OUT_W){SGN & r_acc[OUT_W-1]}}, r_acc};

    // Pick the operation, then clamp once on the full-width sum.
    always_comb begin
        w_sum = align_fn(w_a, A_FRAC, OUT_FRAC, RND);
        if (i_mode == MODE_ADD) w_sum = w_sum + align_fn(w_b, B_FRAC, OUT_FRAC, RND);
        else if (!i_first)      w_sum = w_sum + w_acc;
        w_cl = clamp_fn(w_sum, OUT_W, SGN);
    end

    // After the clamp the upper bits are pure sign/zero fill.
    assign w_unused_hi = ^w_cl.val[MAX_W-1:OUT_W];

    // Stage-1 result and accumulator move only on an accepted sample; ADD leaves acc alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_res <= '0;
            r_sat <= 1'b0;
        end else if (i_accept) begin
            r_res <= w_cl.val[OUT_W-1:0];
            r_sat <= w_cl.sat;
            if (i_mode == MODE_ACC) r_acc <= w_cl.val[OUT_W-1:0];
        end
    end

    assign o_res = r_res;
    assign o_sat = r_sat;

endmodule

// File: rtl/sat_accum_array.sv
// Multi-lane saturating add/accumulate with a stall-aware output delay chain.
module sat_accum_array
    import sa_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int A_W      = 16,
    parameter int A_FRAC   = 0,
    parameter int B_W      = 16,
    parameter int B_FRAC   = 0,
    parameter int OUT_W    = 16,
    parameter int OUT_FRAC = 0,
    parameter int SIGNED   = 0,
    parameter int ROUND    = 1,
    parameter int DELAY    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   stall,
    input  logic                   mode,
    input  logic                   first,
    input  logic [LANES*A_W-1:0]   a_in,
    input  logic [LANES*B_W-1:0]   b_in,
    output logic [LANES*OUT_W-1:0] out,
    output logic [LANES-1:0]       sat,
    output logic                   done
);
    logic                         w_accept;
    logic [DELAY:1]               r_vld_pipe;
    logic [DELAY:0]               w_vld_pipe;
    logic [LANES-1:0][OUT_W-1:0]  w_res1;
    logic [LANES-1:0]             w_sat1;

    assign w_accept = en && !stall;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sat_accum_lane #(
            .A_W(A_W), .A_FRAC(A_FRAC), .B_W(B_W), .B_FRAC(B_FRAC),
            .OUT_W(OUT_W), .OUT_FRAC(OUT_FRAC), .SIGNED(SIGNED), .ROUND(ROUND)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .i_accept (w_accept),
            .i_mode   (mode),
            .i_first  (first),
            .i_a      (a_in[i*A_W +: A_W]),
            .i_b      (b_in[i*B_W +: B_W]),
            .o_res    (w_res1[i]),
            .o_sat    (w_sat1[i])
        );
    end

    // Entry 0 is the incoming accept; when not stalled, en equals accept.
    assign w_vld_pipe = {r_vld_pipe, en};

    // Valid shift register; every stage freezes while stalled.
    always_ff @(posedge clk) begin
        if (reset)       r_vld_pipe <= '0;
        else if (!stall) r_vld_pipe <= w_vld_pipe[DELAY-1:0];
    end

    if (DELAY > 1) begin : g_pipe
        logic [DELAY:2][LANES-1:0][OUT_W-1:0] r_dat;
        logic [DELAY:2][LANES-1:0]            r_st;
        logic [DELAY:1][LANES-1:0][OUT_W-1:0] w_dat_chain;
        logic [DELAY:1][LANES-1:0]            w_st_chain;

        assign w_dat_chain = {r_dat, w_res1};
        assign w_st_chain  = {r_st, w_sat1};

        // Data/flag delay stages behind the lane registers, frozen on stall.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_dat <= '0;
                r_st  <= '0;
            end else if (!stall) begin
                r_dat <= w_dat_chain[DELAY-1:1];
                r_st  <= w_st_chain[DELAY-1:1];
            end
        end

        assign out = r_dat[DELAY];
        assign sat = r_st[DELAY];
    end else begin : g_nopipe
        assign out = w_res1;
        assign sat = w_sat1;
    end

    // In-flight results are dropped by reset and never reported while it is high.
    assign done = r_vld_pipe[DELAY] & ~reset;

endmodule
